// File: rtl/regfile_wb_scheduler_if.sv
// Bundle between decode/issue, the execution-unit writeback requesters,
// the register file write port and the writeback scheduler.
interface regfile_wb_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 3
);
  logic                           issue_valid;
  logic [ADDR_WIDTH-1:0]          issue_rd;
  logic [ADDR_WIDTH-1:0]          issue_rs1;
  logic [ADDR_WIDTH-1:0]          issue_rs2;
  logic                           issue_ready;
  logic                           raw_stall;
  logic [NUM_REQ-1:0]             wb_req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]  wb_req_rd;
  logic [NUM_REQ*DATA_WIDTH-1:0]  wb_req_data;
  logic [NUM_REQ-1:0]             wb_req_ready;
  logic                           rf_write_enable;
  logic [ADDR_WIDTH-1:0]          rf_write_addr;
  logic [DATA_WIDTH-1:0]          rf_write_data;
  logic [31:0]                    busy_vec;

  // Issue and writeback sources drive requests and observe grants/state
  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output wb_req_valid, wb_req_rd, wb_req_data,
    input  issue_ready, raw_stall, wb_req_ready,
    input  rf_write_enable, rf_write_addr, rf_write_data, busy_vec
  );

  // The scheduler consumes requests and drives grants, write port and scoreboard
  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  wb_req_valid, wb_req_rd, wb_req_data,
    output issue_ready, raw_stall, wb_req_ready,
    output rf_write_enable, rf_write_addr, rf_write_data, busy_vec
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and register scoreboard for the 32-entry integer
// register file: round-robin arbitration of writeback requesters onto the
// single write port, a busy bit per register, and RAW/WAW issue gating.
module regfile_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr_r;
  logic [PTR_W-1:0]      scan_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic                  grant_any_s;
  logic [ADDR_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [31:0]           busy_r;
  logic [31:0]           busy_next_s;
  logic                  raw_s;
  logic                  waw_s;
  logic                  accept_s;
  logic                  rf_we_r;
  logic [ADDR_WIDTH-1:0] rf_addr_r;
  logic [DATA_WIDTH-1:0] rf_data_r;

  // Requester index after p, wrapping at NUM_REQ (NUM_REQ need not be a power of two)
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (int'(p) >= NUM_REQ - 1) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Round-robin pick: first valid requester starting at rr_ptr
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    scan_s      = rr_ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any_s && bus.wb_req_valid[scan_s]) begin
        grant_any_s     = 1'b1;
        grant_s[scan_s] = 1'b1;
        grant_idx_s     = scan_s;
      end else begin
        grant_any_s = grant_any_s;
      end
      scan_s = wrap_inc(scan_s);
    end
  end

  // Mux the granted requester's destination and result
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    if (grant_any_s) begin
      sel_rd_s   = bus.wb_req_rd[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data_s = bus.wb_req_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      sel_rd_s   = '0;
      sel_data_s = '0;
    end
  end

  // Hazard checks; busy_r[0] is held at 0 so x0 never hazards
  always_comb begin
    raw_s    = bus.issue_valid & (busy_r[bus.issue_rs1] | busy_r[bus.issue_rs2]);
    waw_s    = bus.issue_valid & busy_r[bus.issue_rd];
    accept_s = bus.issue_valid & ~raw_s & ~waw_s;
  end

  // Scoreboard update: clear on the landing write, set on issue (set wins)
  always_comb begin
    busy_next_s = busy_r;
    if (rf_we_r) begin
      busy_next_s[rf_addr_r] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (accept_s && (bus.issue_rd != '0)) begin
      busy_next_s[bus.issue_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard and round-robin pointer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r   <= 32'd0;
      rr_ptr_r <= '0;
    end else begin
      busy_r <= busy_next_s;
      if (grant_any_s) begin
        rr_ptr_r <= wrap_inc(grant_idx_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // One-cycle write stage toward the register file; x0 writes are dropped here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_r   <= 1'b0;
      rf_addr_r <= '0;
      rf_data_r <= '0;
    end else begin
      rf_we_r <= grant_any_s && (sel_rd_s != '0);
      if (grant_any_s) begin
        rf_addr_r <= sel_rd_s;
        rf_data_r <= sel_data_s;
      end else begin
        rf_addr_r <= rf_addr_r;
        rf_data_r <= rf_data_r;
      end
    end
  end

  assign bus.issue_ready     = accept_s;
  assign bus.raw_stall       = raw_s;
  assign bus.wb_req_ready    = grant_s;
  assign bus.rf_write_enable = rf_we_r;
  assign bus.rf_write_addr   = rf_addr_r;
  assign bus.rf_write_data   = rf_data_r;
  assign bus.busy_vec        = busy_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler. Expected register-file writes are
// queued as requests are presented; a monitor pops and compares each write.
module tb_regfile_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  regfile_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_issue(input logic v, input logic [AW-1:0] rd,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.issue_valid = v;
    bus.issue_rd    = rd;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.wb_req_valid[i]        = v;
    bus.wb_req_rd[i*AW +: AW]  = rd;
    bus.wb_req_data[i*DW +: DW] = d;
  endtask

  task automatic expect_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  // Monitor: every register-file write must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rf_write_enable !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.rf_write_addr, bus.rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.rf_write_addr), 64'(mon_e[AW+DW-1:DW]));
        check("wr_data", bus.rf_write_data, mon_e[DW-1:0]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.wb_req_valid = '0;
    bus.wb_req_rd    = '0;
    bus.wb_req_data  = '0;
    #1;
    check("rst_busy", 64'(bus.busy_vec), 64'h0);
    check("rst_we", 64'(bus.rf_write_enable), 64'h0);
    check("rst_addr", 64'(bus.rf_write_addr), 64'h0);
    check("rst_data", bus.rf_write_data, 64'h0);
    tick();
    tick();
    reset = 1'b1;

    // Issue-to-writeback: rd=5 issued, written back three cycles later
    tick();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1 check("iw_ready", 64'(bus.issue_ready), 64'h1);
    check("iw_raw", 64'(bus.raw_stall), 64'h0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("iw_busy_set", 64'(bus.busy_vec), 64'h20);
    tick();
    tick();
    set_req(0, 1'b1, 5'd5, 64'hDEAD);
    expect_write(5'd5, 64'hDEAD);
    #1 check("iw_grant", 64'(bus.wb_req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    #1 check("iw_busy_wstage", 64'(bus.busy_vec), 64'h20);
    check("iw_we", 64'(bus.rf_write_enable), 64'h1);
    tick();
    #1 check("iw_busy_clr", 64'(bus.busy_vec), 64'h0);

    // RAW: rs1=7 stalls until the cycle after the write to 7 commits (rr_ptr=1)
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    #1 check("raw_prod_ready", 64'(bus.issue_ready), 64'h1);
    tick();
    set_issue(1'b1, 5'd8, 5'd7, 5'd0);
    #1 check("raw_stall0", 64'(bus.raw_stall), 64'h1);
    check("raw_ready0", 64'(bus.issue_ready), 64'h0);
    set_req(2, 1'b1, 5'd7, 64'h77);
    expect_write(5'd7, 64'h77);
    #1 check("raw_grant", 64'(bus.wb_req_ready), 64'h4);
    tick();
    set_req(2, 1'b0, 5'd0, 64'h0);
    #1 check("raw_stall_wstage", 64'(bus.raw_stall), 64'h1);
    check("raw_ready_wstage", 64'(bus.issue_ready), 64'h0);
    tick();
    #1 check("raw_stall_done", 64'(bus.raw_stall), 64'h0);
    check("raw_ready_done", 64'(bus.issue_ready), 64'h1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("raw_busy", 64'(bus.busy_vec), 64'h100);

    // Round robin from rr_ptr=0 with all requesters valid
    set_req(0, 1'b1, 5'd1, 64'hA0);
    set_req(1, 1'b1, 5'd2, 64'hA1);
    set_req(2, 1'b1, 5'd3, 64'hA2);
    for (int c = 0; c < 6; c++) begin
      #1 check("rr_grant", 64'(bus.wb_req_ready), 64'(1 << (c % 3)));
      expect_write(5'(1 + (c % 3)), 64'hA0 + 64'(c % 3));
      tick();
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'd0, 64'h0);
    tick();
    tick();
    #1 check("rr_busy", 64'(bus.busy_vec), 64'h100);

    // x0 handling
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_ready", 64'(bus.issue_ready), 64'h1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("x0_busy", 64'(bus.busy_vec), 64'h100);
    set_req(1, 1'b1, 5'd0, 64'h55);
    #1 check("x0_grant", 64'(bus.wb_req_ready), 64'h2);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    #1 check("x0_we0", 64'(bus.rf_write_enable), 64'h0);
    tick();
    #1 check("x0_we1", 64'(bus.rf_write_enable), 64'h0);
    check("x0_busy_after", 64'(bus.busy_vec), 64'h100);

    // WAW: rd=9 blocked until its pending write clears (rr_ptr=2)
    set_issue(1'b1, 5'd9, 5'd0, 5'd0);
    #1 check("waw_first", 64'(bus.issue_ready), 64'h1);
    tick();
    #1 check("waw_ready0", 64'(bus.issue_ready), 64'h0);
    check("waw_raw0", 64'(bus.raw_stall), 64'h0);
    set_req(0, 1'b1, 5'd9, 64'h99);
    expect_write(5'd9, 64'h99);
    #1 check("waw_grant", 64'(bus.wb_req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    #1 check("waw_ready_wstage", 64'(bus.issue_ready), 64'h0);
    tick();
    #1 check("waw_ready_done", 64'(bus.issue_ready), 64'h1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("waw_busy", 64'(bus.busy_vec), 64'h300);

    // Drain 8 and 9 (rr_ptr=1), then build busy=0xF0 for the reset test
    set_req(1, 1'b1, 5'd8, 64'h88);
    set_req(2, 1'b1, 5'd9, 64'h9999);
    expect_write(5'd8, 64'h88);
    #1 check("drain_g1", 64'(bus.wb_req_ready), 64'h2);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    expect_write(5'd9, 64'h9999);
    #1 check("drain_g2", 64'(bus.wb_req_ready), 64'h4);
    tick();
    set_req(2, 1'b0, 5'd0, 64'h0);
    tick();
    tick();
    #1 check("drain_busy", 64'(bus.busy_vec), 64'h0);
    for (int r = 4; r < 8; r++) begin
      set_issue(1'b1, 5'(r), 5'd0, 5'd0);
      #1 check("fill_ready", 64'(bus.issue_ready), 64'h1);
      tick();
    end
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_req(0, 1'b1, 5'd1, 64'h11);
    expect_write(5'd1, 64'h11);
    #1 check("fill_grant", 64'(bus.wb_req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    #2 check("pre_rst_busy", 64'(bus.busy_vec), 64'hF0);
    check("pre_rst_we", 64'(bus.rf_write_enable), 64'h1);
    reset = 1'b0;
    #1 check("mid_rst_busy", 64'(bus.busy_vec), 64'h0);
    check("mid_rst_we", 64'(bus.rf_write_enable), 64'h0);
    check("mid_rst_addr", 64'(bus.rf_write_addr), 64'h0);
    check("mid_rst_data", bus.rf_write_data, 64'h0);
    tick();
    tick();
    reset = 1'b1;

    // After reset the round-robin pointer starts at requester 0 again
    set_req(0, 1'b1, 5'd2, 64'hB0);
    set_req(1, 1'b1, 5'd3, 64'hB1);
    expect_write(5'd2, 64'hB0);
    #1 check("post_rst_grant", 64'(bus.wb_req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    set_req(1, 1'b0, 5'd0, 64'h0);
    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
